// File: rtl/rsa_arb_pkg.sv
// Shared types for the RSA job arbiter.
// Job FSM states and the operand width.
package rsa_arb_pkg;

  localparam int RSA_W = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP,
    S_ABORT
  } state_e;

endpackage

// File: rtl/rsa_job_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Grants the first set request after last_i, wrapping around.
module rr_pick #(
  parameter int N  = 2,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [LW-1:0] last_i,
  output logic [LW-1:0] grant_o,
  output logic          valid_o
);

  logic [LW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int i = N; i >= 1; i--) begin
      idx = LW'((int'(last_i) + i) % N);
      if (req_i[idx]) begin
        grant_o = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rsa_job_arbiter.sv
// Round-robin sharing of one RSA core between requesters.
// Latches operands, launches the core, returns result or watchdog error.
module rsa_job_arbiter
  import rsa_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 131071,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*RSA_W-1:0] i_a,
  input  logic [NUM_REQ*RSA_W-1:0] i_d,
  input  logic [NUM_REQ*RSA_W-1:0] i_n,
  output logic [NUM_REQ-1:0]       o_ack,
  output logic [NUM_REQ-1:0]       o_done,
  output logic [NUM_REQ-1:0]       o_err,
  output logic [RSA_W-1:0]         o_result,
  output logic                     o_busy,
  output logic                     o_core_rst,
  output logic                     o_core_start,
  output logic [RSA_W-1:0]         o_core_a,
  output logic [RSA_W-1:0]         o_core_d,
  output logic [RSA_W-1:0]         o_core_n,
  input  logic [RSA_W-1:0]         i_core_result,
  input  logic                     i_core_finished
);

  localparam int LW = $clog2(NUM_REQ);

  state_e               state_q, state_d;
  logic [LW-1:0]        g_q, g_d;
  logic [LW-1:0]        last_q, last_d;
  logic [LW-1:0]        pick;
  logic                 pick_v;
  logic [TW-1:0]        wd_q, wd_d;
  logic [RSA_W-1:0]     a_q, a_d;
  logic [RSA_W-1:0]     d_q, d_d;
  logic [RSA_W-1:0]     n_q, n_d;
  logic [RSA_W-1:0]     res_q, res_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic                 start_q, start_d;

  rr_pick #(
    .N  (NUM_REQ),
    .LW (LW)
  ) u_pick (
    .req_i   (i_req),
    .last_i  (last_q),
    .grant_o (pick),
    .valid_o (pick_v)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      last_q  <= LW'(NUM_REQ - 1);
      wd_q    <= '0;
      a_q     <= '0;
      d_q     <= '0;
      n_q     <= '0;
      res_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      a_q     <= a_d;
      d_q     <= d_d;
      n_q     <= n_d;
      res_q   <= res_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end

  // Pulses are computed one state early so they register into the target state.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    wd_d    = wd_q;
    a_d     = a_q;
    d_d     = d_q;
    n_d     = n_q;
    res_d   = res_q;
    ack_d   = '0;
    done_d  = '0;
    err_d   = '0;
    start_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_v) begin
          g_d         = pick;
          a_d         = i_a[pick*RSA_W +: RSA_W];
          d_d         = i_d[pick*RSA_W +: RSA_W];
          n_d         = i_n[pick*RSA_W +: RSA_W];
          ack_d[pick] = 1'b1;
          start_d     = 1'b1;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_core_finished) begin
          res_d       = i_core_result;
          done_d[g_q] = 1'b1;
          state_d     = S_RESP;
        end else if (wd_q == TW'(TIMEOUT - 1)) begin
          err_d[g_q] = 1'b1;
          state_d    = S_ABORT;
        end else begin
          wd_d = wd_q + TW'(1);
        end
      end
      S_RESP, S_ABORT: begin
        last_d  = g_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_ack        = ack_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_result     = res_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_core_rst   = i_rst | (state_q == S_ABORT);
  assign o_core_start = start_q;
  assign o_core_a     = a_q;
  assign o_core_d     = d_q;
  assign o_core_n     = n_q;

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Bench for rsa_job_arbiter: table vectors, corner sequences, random jobs.
// A behavioural core stub supplies results with programmable latency.
module tb_rsa_job_arbiter;

  localparam int NR = 3;
  localparam int TO = 16;
  localparam int W  = 256;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req = '0;
  logic [NR*W-1:0] a_f = '0;
  logic [NR*W-1:0] d_f = '0;
  logic [NR*W-1:0] n_f = '0;
  logic [NR-1:0]   o_ack, o_done, o_err;
  logic [W-1:0]    o_result, o_core_a, o_core_d, o_core_n;
  logic            o_busy, o_core_rst, o_core_start;
  logic [W-1:0]    core_res = '0;
  logic            core_fin = 1'b0;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int cnt = 0;
  int cur_fin = 0;
  bit cur_nev = 1'b0;
  bit hold = 1'b0;
  int last_m = NR - 1;

  longint unsigned op_a[NR], op_d[NR], op_n[NR];
  int              fin_cfg[NR];
  bit              nev_cfg[NR];

  typedef struct {
    int              r;
    longint unsigned a, d, n;
    int              fin;
    longint unsigned exp;
  } vec_t;

  vec_t tbl[5];

  rsa_job_arbiter #(
    .NUM_REQ (NR),
    .TIMEOUT (TO)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req           (req),
    .i_a             (a_f),
    .i_d             (d_f),
    .i_n             (n_f),
    .o_ack           (o_ack),
    .o_done          (o_done),
    .o_err           (o_err),
    .o_result        (o_result),
    .o_busy          (o_busy),
    .o_core_rst      (o_core_rst),
    .o_core_start    (o_core_start),
    .o_core_a        (o_core_a),
    .o_core_d        (o_core_d),
    .o_core_n        (o_core_n),
    .i_core_result   (core_res),
    .i_core_finished (core_fin)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic longint unsigned modexp(longint unsigned b,
                                             longint unsigned e,
                                             longint unsigned m);
    longint unsigned r;
    r = 1 % m;
    b = b % m;
    while (e != 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  // Core stub: finishes during WAIT cycle cur_fin, or never.
  always @(posedge clk) begin
    core_fin <= 1'b0;
    if (o_core_rst) begin
      cnt <= 0;
    end else if (o_core_start) begin
      core_res <= W'(modexp(o_core_a[63:0], o_core_d[63:0], o_core_n[63:0]));
      if (!cur_nev) begin
        if (cur_fin == 0) core_fin <= 1'b1;
        else cnt <= cur_fin;
      end
    end else if (cnt != 0) begin
      if (cnt == 1) core_fin <= 1'b1;
      cnt <= cnt - 1;
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int model_pick();
    for (int k = 1; k <= NR; k++)
      if (req[(last_m + k) % NR]) return (last_m + k) % NR;
    return -1;
  endfunction

  task automatic raise(input int r, input longint unsigned a,
                       input longint unsigned d, input longint unsigned n,
                       input int fin, input bit nev);
    op_a[r] = a;
    op_d[r] = d;
    op_n[r] = n;
    fin_cfg[r] = fin;
    nev_cfg[r] = nev;
    a_f[r*W +: W] = W'(a);
    d_f[r*W +: W] = W'(d);
    n_f[r*W +: W] = W'(n);
    req[r] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    hold = 1'b0;
    cur_nev = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_ack", o_ack, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_start", o_core_start, 0);
    chk("rst_result", o_result, 0);
    chk("rst_core_a", o_core_a, 0);
    chk("rst_core_rst", o_core_rst, 1);
    rst = 1'b0;
    last_m = NR - 1;
  endtask

  // Returns at the negedge of the IDLE cycle following RESP/ABORT.
  task automatic serve(output int g, output logic [W-1:0] res,
                       output int waited);
    bit got;
    int t0;
    int exp_g;
    logic [NR-1:0] ov;
    g = -1;
    res = '0;
    waited = -1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (o_ack != 0) begin
        got = 1'b1;
        waited = i;
      end
    end
    if (!got) begin
      chk("ack_timeout", 0, 1);
      return;
    end
    for (int k = 0; k < NR; k++) if (o_ack[k]) g = k;
    exp_g = model_pick();
    chk("ack_onehot", $countones(o_ack), 1);
    chk("ack_pick", g, exp_g);
    chk("start_with_ack", o_core_start, 1);
    chk("busy_launch", o_busy, 1);
    chk("core_a", o_core_a, W'(op_a[g]));
    chk("core_d", o_core_d, W'(op_d[g]));
    chk("core_n", o_core_n, W'(op_n[g]));
    cur_fin = fin_cfg[g];
    cur_nev = nev_cfg[g];
    if (!hold) req[g] = 1'b0;
    t0 = cyc;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (o_done != 0 || o_err != 0) got = 1'b1;
    end
    if (!got) begin
      chk("end_timeout", 0, 1);
      return;
    end
    ov = '0;
    ov[g] = 1'b1;
    if (nev_cfg[g]) begin
      chk("err_bit", o_err, ov);
      chk("abort_no_done", o_done, 0);
      chk("abort_core_rst", o_core_rst, 1);
      chk("abort_lat", cyc - t0, TO + 1);
    end else begin
      chk("done_bit", o_done, ov);
      chk("done_no_err", o_err, 0);
      chk("result", o_result, W'(modexp(op_a[g], op_d[g], op_n[g])));
      chk("done_lat", cyc - t0, fin_cfg[g] + 2);
    end
    res = o_result;
    last_m = g;
    @(negedge clk);
    chk("idle_busy", o_busy, 0);
    chk("idle_core_rst", o_core_rst, 0);
    chk("idle_pulses", {o_done, o_err}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int g, w, pulses;
    logic [W-1:0] res;
    longint unsigned n, a;

    tbl[0] = '{0, 2, 10, 1000003, 3, 1024};
    tbl[1] = '{1, 5, 0, 7, 1, 1};
    tbl[2] = '{2, 11, 3, 13, 7, 5};
    tbl[3] = '{0, 4, 13, 497, 15, 445};
    tbl[4] = '{1, 3, 5, 101, 0, 41};

    do_reset();

    for (int i = 0; i < 5; i++) begin
      raise(tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].n, tbl[i].fin, 1'b0);
      serve(g, res, w);
      chk("tbl_grant", g, tbl[i].r);
      chk("tbl_result", res, W'(tbl[i].exp));
      chk("tbl_ack_wait", w, 0);
    end

    do_reset();
    raise(0, 3, 5, 101, 2, 1'b0);
    raise(1, 7, 3, 55, 4, 1'b0);
    serve(g, res, w);
    chk("simul_first", g, 0);
    chk("simul_res0", res, 41);
    serve(g, res, w);
    chk("simul_second", g, 1);
    chk("simul_res1", res, 13);
    chk("simul_regrant_wait", w, 0);

    hold = 1'b1;
    raise(0, 6, 7, 1009, 2, 1'b0);
    raise(1, 8, 9, 2003, 5, 1'b0);
    for (int j = 0; j < 4; j++) begin
      serve(g, res, w);
      chk("fair_order", g, j % 2);
    end
    req = '0;
    hold = 1'b0;

    raise(2, 5, 5, 77, 0, 1'b1);
    serve(g, res, w);
    chk("wd_grant", g, 2);
    raise(0, 10, 11, 4099, 6, 1'b0);
    serve(g, res, w);
    chk("wd_recover", g, 0);

    raise(0, 9, 7, 1009, 10, 1'b0);
    w = -1;
    for (int i = 0; i < 10 && w < 0; i++) begin
      @(negedge clk);
      if (o_ack[0]) w = i;
    end
    chk("mid_ack", w, 0);
    cur_fin = 10;
    cur_nev = 1'b0;
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_busy", o_busy, 0);
    chk("mid_pulses", {o_ack, o_done, o_err, o_core_start}, 0);
    chk("mid_result", o_result, 0);
    chk("mid_core_a", o_core_a, 0);
    chk("mid_core_rst", o_core_rst, 1);
    rst = 1'b0;
    last_m = NR - 1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_done != 0 || o_err != 0) pulses++;
    end
    chk("mid_silent", pulses, 0);
    raise(1, 12, 5, 9973, 4, 1'b0);
    serve(g, res, w);
    chk("mid_fresh", g, 1);

    do_reset();
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < NR; r++) begin
        if (!req[r] && $urandom_range(1, 0) == 1) begin
          n = longint'($urandom_range(1 << 20, 3)) | 1;
          a = longint'($urandom) % n;
          raise(r, a, longint'($urandom_range(65535, 0)), n,
                $urandom_range(15, 0), $urandom_range(9, 0) == 0);
        end
      end
      if (req == 0) begin
        n = longint'($urandom_range(1 << 20, 3)) | 1;
        a = longint'($urandom) % n;
        raise($urandom_range(NR - 1, 0), a,
              longint'($urandom_range(65535, 0)), n,
              $urandom_range(15, 0), 1'b0);
      end
      serve(g, res, w);
      chk("rand_ack_wait", w, 0);
    end
    req = '0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rsa_job_arbiter.md
Name: rsa_job_arbiter

Overview:
- Shares one Rsa256Core between NUM_REQ independent requesters using round-robin arbitration.
- Per job: latches the granted requester's operands, pulses core start, and waits for core finished under a watchdog.
- On completion, returns the result to that requester with a done pulse.
- On watchdog expiry, resets the core and returns an error pulse. Sits between the host-side command logic and the core.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 131071, max WAIT cycles before abort. Core worst case ≈ 66,000 cycles.
- TW, $clog2(TIMEOUT+1), watchdog counter width (derived; do not override).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req  in  NUM_REQ  level request per requester; held until its o_ack
- i_a  in  NUM_REQ*256  operand a (ciphertext); slice k belongs to requester k
- i_d  in  NUM_REQ*256  exponent per requester
- i_n  in  NUM_REQ*256  modulus per requester
- o_ack  out  NUM_REQ  one-cycle pulse: operands captured
- o_done  out  NUM_REQ  one-cycle pulse: o_result valid for this requester
- o_err  out  NUM_REQ  one-cycle pulse: job aborted by watchdog
- o_result  out  256  result; valid only while some o_done bit is high
- o_busy  out  1  high in every state except IDLE
- o_core_rst  out  1  core reset; equals i_rst OR (state==ABORT)
- o_core_start  out  1  core start pulse
- o_core_a  out  256  latched a
- o_core_d  out  256  latched d
- o_core_n  out  256  latched n
- i_core_result  in  256  core result
- i_core_finished  in  1  core finished pulse

Behaviour:
- Clock and reset:
  - Single clock i_clk.
  - i_rst is synchronous and active-high.
  - Reset values:
    - state=IDLE.
    - All o_ack/o_done/o_err/o_core_start = 0.
    - o_result = 0; operand registers = 0.
    - o_busy = 0.
    - Round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
- Reset mid-job: the job is discarded silently (no o_done/o_err), and o_core_rst is high during reset.
- All pulse outputs are registered.
- States:
  - IDLE:
    - If i_req != 0, grant g = first set bit searching from last+1 upward with wrap.
    - Latch i_a/i_d/i_n slice g into o_core_*; store g.
    - Go to LAUNCH.
    - i_req is sampled only in IDLE; requests arriving while busy wait.
  - LAUNCH (1 cycle):
    - o_ack[g]=1 and o_core_start=1 in the same cycle.
    - Clear watchdog; go to WAIT.
  - WAIT:
    - Watchdog increments each cycle.
    - If i_core_finished: latch i_core_result into o_result; go to RESP.
    - Else if watchdog == TIMEOUT-1: go to ABORT.
    - If finished and the timeout condition occur in the same cycle, finished wins.
  - RESP (1 cycle):
    - o_done[g]=1 with o_result valid.
    - last = g; go to IDLE.
  - ABORT (1 cycle):
    - o_core_rst=1 and o_err[g]=1.
    - last = g; go to IDLE.
- Arbitration and latency:
  - A request sampled in IDLE at edge k gets o_ack at cycle k+1.
  - The next grant can be sampled in IDLE one cycle after RESP or ABORT.
  - Requester-to-done latency = core latency + 3 cycles.
- o_core_a/d/n stay stable from LAUNCH through RESP/ABORT. Requesters may change operands after o_ack.
- A requester keeping i_req high after its o_ack is treated as a new job. It re-arbitrates behind the other requesters because of the pointer update.
- i_core_finished is ignored outside WAIT.
- Requesters must supply an odd n with a, n < 2^256, as the core requires. The arbiter does not check this.

Decomposition:
- Package rsa_arb_pkg:
  - state enum (IDLE, LAUNCH, WAIT, RESP, ABORT; 3 bits);
  - RSA_W = 256 constant.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, last index.
  - Outputs: grant index and valid.
  - Reusable elsewhere in the codebase.

Test Plan:
- Single job, real core: req0 with a=2, d=10, n=1000003 → o_ack[0] exactly 1 cycle after sampling; o_core_start coincident; o_done[0] with o_result=1024; o_busy falls the cycle after.
- Simultaneous requests from reset: i_req=2'b11, req0 (a=3,d=5,n=101 → 41), req1 (a=7,d=3,n=55 → 13) → req0 served first then req1; o_ack order 0,1; results 41 then 13.
- Fairness: both requests held high continuously for 4 jobs → grant order 0,1,0,1.
- Watchdog: stub core that never finishes, TIMEOUT=16 → ABORT reached 16 WAIT cycles after LAUNCH; o_err[g] and o_core_rst high for 1 cycle; no o_done; next request then completes normally.
- Boundary: stub asserts finished on exactly the timeout cycle → RESP taken, o_done=1, o_err=0.
- Reset mid-job: assert i_rst during WAIT → next cycle all outputs at reset values, no done/err pulse; o_core_rst high while i_rst is high; fresh job afterward succeeds.
